aes_round_sequencer: RTL and testbench

//  Parametrised round sequencer for the iterative AES datapath. Supports AES-128/192/256
//  (Nr = 10/12/14) and an encrypt/decrypt mode. Issues one-cycle start pulses to the

---
 rtl/aes_seq_if.sv | 36 +++
 rtl/aes_round_sequencer.sv | 165 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_if.sv
// Handshake bundle between the AES round sequencer and its environment:
// block control, unit start/ready pulses, ARK mux select and status.
interface aes_seq_if #(
    parameter int RW = 4
);
    logic          start_in;
    logic [1:0]    key_len_in;
    logic          dec_in;
    logic          abort_in;
    logic          ss_ready_in;
    logic          mc_ready_in;
    logic          ark_ready_in;
    logic          ss_start_out;
    logic          mc_start_out;
    logic          ark_start_out;
    logic [2:0]    ark_in_sel;
    logic [RW-1:0] round_out;
    logic [RW-1:0] key_idx_out;
    logic          busy_out;
    logic          done_out;
    logic          err_out;

    modport master (
        output start_in, key_len_in, dec_in, abort_in,
        output ss_ready_in, mc_ready_in, ark_ready_in,
        input  ss_start_out, mc_start_out, ark_start_out, ark_in_sel,
        input  round_out, key_idx_out, busy_out, done_out, err_out
    );

    modport slave (
        input  start_in, key_len_in, dec_in, abort_in,
        input  ss_ready_in, mc_ready_in, ark_ready_in,
        output ss_start_out, mc_start_out, ark_start_out, ark_in_sel,
        output round_out, key_idx_out, busy_out, done_out, err_out
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Round sequencer for an iterative AES datapath (AES-128/192/256, enc/dec).
// Walks ARK -> (SS -> MC -> ARK) x (Nr-1) -> SS -> ARK, issuing one-cycle
// start pulses and waiting for each unit's ready pulse. The final round
// skips MixColumns and feeds ARK straight from the SS output.
module aes_round_sequencer #(
    parameter int MAX_ROUNDS = 14,
    parameter int RW         = 4
) (
    input  logic      clk,
    input  logic      rst,
    aes_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        W_ARK = 2'd1,
        W_SS  = 2'd2,
        W_MC  = 2'd3
    } state_t;

    localparam logic [4:0] MAX_NR = 5'(MAX_ROUNDS);

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_DATA = 3'b001;
    localparam logic [2:0] SEL_SS   = 3'b010;
    localparam logic [2:0] SEL_MC   = 3'b100;

    state_t        state_r;
    logic [RW-1:0] nr_r;
    logic          dec_r;
    logic [RW-1:0] round_r;
    logic [RW-1:0] key_idx_r;
    logic [2:0]    sel_r;
    logic          ss_start_r;
    logic          mc_start_r;
    logic          ark_start_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    logic [4:0]    req_nr_s;
    logic          key_ok_s;
    logic [RW-1:0] round_nx_s;

    // Number of rounds for a key-length code; 0 marks the reserved code.
    function automatic logic [4:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b00:   nr_of = 5'd10;
            2'b01:   nr_of = 5'd12;
            2'b10:   nr_of = 5'd14;
            default: nr_of = 5'd0;
        endcase
    endfunction

    // Decode the requested key length and precompute the next round number.
    always_comb begin
        req_nr_s   = nr_of(bus.key_len_in);
        key_ok_s   = (req_nr_s != 5'd0) && (req_nr_s <= MAX_NR);
        round_nx_s = round_r + RW'(1);
    end

    // Sequencer FSM; every output is a register, start/done/err pulses self-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            nr_r        <= '0;
            dec_r       <= 1'b0;
            round_r     <= '0;
            key_idx_r   <= '0;
            sel_r       <= SEL_NONE;
            ss_start_r  <= 1'b0;
            mc_start_r  <= 1'b0;
            ark_start_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ss_start_r  <= 1'b0;
            mc_start_r  <= 1'b0;
            ark_start_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            if (bus.abort_in && (state_r != IDLE)) begin
                // Abort outranks any ready arriving in the same cycle.
                state_r   <= IDLE;
                round_r   <= '0;
                key_idx_r <= '0;
                sel_r     <= SEL_NONE;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.start_in && !bus.abort_in) begin
                            if (key_ok_s) begin
                                nr_r        <= RW'(req_nr_s);
                                dec_r       <= bus.dec_in;
                                round_r     <= '0;
                                key_idx_r   <= bus.dec_in ? RW'(req_nr_s) : '0;
                                sel_r       <= SEL_DATA;
                                ark_start_r <= 1'b1;
                                busy_r      <= 1'b1;
                                state_r     <= W_ARK;
                            end else begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                    W_ARK: begin
                        if (bus.ark_ready_in) begin
                            if (round_r == nr_r) begin
                                done_r    <= 1'b1;
                                busy_r    <= 1'b0;
                                round_r   <= '0;
                                key_idx_r <= '0;
                                sel_r     <= SEL_NONE;
                                state_r   <= IDLE;
                            end else begin
                                round_r    <= round_nx_s;
                                key_idx_r  <= dec_r ? (nr_r - round_nx_s) : round_nx_s;
                                ss_start_r <= 1'b1;
                                state_r    <= W_SS;
                            end
                        end
                    end
                    W_SS: begin
                        if (bus.ss_ready_in) begin
                            if (round_r < nr_r) begin
                                mc_start_r <= 1'b1;
                                state_r    <= W_MC;
                            end else begin
                                // Final round: no MixColumns, ARK takes the SS output.
                                sel_r       <= SEL_SS;
                                ark_start_r <= 1'b1;
                                state_r     <= W_ARK;
                            end
                        end
                    end
                    W_MC: begin
                        if (bus.mc_ready_in) begin
                            sel_r       <= SEL_MC;
                            ark_start_r <= 1'b1;
                            state_r     <= W_ARK;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        round_r   <= '0;
                        key_idx_r <= '0;
                        sel_r     <= SEL_NONE;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ss_start_out  = ss_start_r;
    assign bus.mc_start_out  = mc_start_r;
    assign bus.ark_start_out = ark_start_r;
    assign bus.ark_in_sel    = sel_r;
    assign bus.round_out     = round_r;
    assign bus.key_idx_out   = key_idx_r;
    assign bus.busy_out      = busy_r;
    assign bus.done_out      = done_r;
    assign bus.err_out       = err_r;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: a table of block requests
// plus hand-built abort/reset/start-while-busy sequences, with randomized
// unit reply latencies and stray ready pulses.
module tb_aes_round_sequencer;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_seq_if #(.RW(RW)) bus();

    aes_round_sequencer #(.MAX_ROUNDS(14), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int unit;   // 0 = ARK, 1 = SS, 2 = MC
        int sel;    // expected ark_in_sel for ARK starts
        int rnd;    // expected round_out while the start is visible
    } ev_t;

    typedef struct {
        logic [1:0] kl;
        logic       d;
        bit         exp_err;
        int         exp_ark;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_nr(input logic [1:0] kl);
        if (kl == 2'b00) return 10;
        if (kl == 2'b01) return 12;
        if (kl == 2'b10) return 14;
        return 0;
    endfunction

    function automatic int all_outputs();
        return int'(bus.ss_start_out) + int'(bus.mc_start_out) + int'(bus.ark_start_out)
             + int'(bus.ark_in_sel) + int'(bus.round_out) + int'(bus.key_idx_out)
             + int'(bus.busy_out) + int'(bus.done_out) + int'(bus.err_out);
    endfunction

    task automatic idle_inputs();
        bus.start_in     = 1'b0;
        bus.key_len_in   = 2'b00;
        bus.dec_in       = 1'b0;
        bus.abort_in     = 1'b0;
        bus.ss_ready_in  = 1'b0;
        bus.mc_ready_in  = 1'b0;
        bus.ark_ready_in = 1'b0;
    endtask

    // Run one block. abort_rnd >= 0: abort together with mc_ready in that round.
    // rst_rnd >= 0: pull reset when the first start of that round appears.
    task automatic run_block(input logic [1:0] kl, input logic d, input int lat_max,
                             input bit inj, input int abort_rnd, input int rst_rnd,
                             output int n_ark);
        ev_t q[$];
        int  nr, pend, punit, n_ss, n_mc;
        bit  fin, ab, aborted, last_final;
        nr = model_nr(kl);
        n_ark = 0; n_ss = 0; n_mc = 0;
        q.push_back('{0, 1, 0});
        for (int r = 1; r <= nr; r++) begin
            q.push_back('{1, 0, r});
            if (r < nr) begin
                q.push_back('{2, 0, r});
                q.push_back('{0, 4, r});
            end else begin
                q.push_back('{0, 2, r});
            end
        end
        idle_inputs();
        bus.key_len_in = kl; bus.dec_in = d; bus.start_in = 1'b1;
        @(posedge clk); #1;
        pend = -1; punit = 0; fin = 1'b0; ab = 1'b0; aborted = 1'b0; last_final = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            int ns;
            if (aborted) begin
                check("abort_busy", bus.busy_out, 0);
                check("abort_round", bus.round_out, 0);
                check("abort_sel", bus.ark_in_sel, 0);
                check("abort_no_ark_start", bus.ark_start_out, 0);
                check("abort_no_done", bus.done_out, 0);
                idle_inputs();
                bus.mc_ready_in = 1'b1;
                @(posedge clk); #1;
                bus.mc_ready_in = 1'b0;
                check("late_mc_ready_ignored",
                      int'(bus.ss_start_out) + int'(bus.mc_start_out) + int'(bus.ark_start_out)
                      + int'(bus.busy_out), 0);
                return;
            end
            ns = int'(bus.ark_start_out) + int'(bus.ss_start_out) + int'(bus.mc_start_out);
            check("starts_per_cycle_le1", int'(ns <= 1), 1);
            if (ns == 1) begin
                int  u;
                ev_t e;
                u = bus.ark_start_out ? 0 : (bus.ss_start_out ? 1 : 2);
                if (q.size() == 0) begin
                    check("unexpected_start_unit", u, -1);
                end else begin
                    e = q.pop_front();
                    check("start_unit", u, e.unit);
                    check("round_out", int'(bus.round_out), e.rnd);
                    check("key_idx_out", int'(bus.key_idx_out), d ? (nr - e.rnd) : e.rnd);
                    if (u == 0) check("ark_in_sel", int'(bus.ark_in_sel), e.sel);
                    if (u == 0) n_ark++;
                    if (u == 1) n_ss++;
                    if (u == 2) n_mc++;
                    punit = u;
                    pend  = $urandom_range(0, lat_max);
                    if (abort_rnd >= 0 && u == 2 && e.rnd == abort_rnd) begin
                        ab   = 1'b1;
                        pend = 0;
                    end
                    if (rst_rnd >= 0 && e.rnd == rst_rnd) begin
                        rst = 1'b0;
                        #1;
                        check("async_reset_outputs_zero", all_outputs(), 0);
                        idle_inputs();
                        @(negedge clk);
                        rst = 1'b1;
                        return;
                    end
                end
            end
            check("done_out", bus.done_out, last_final);
            check("busy_out", bus.busy_out, !last_final);
            check("err_out_in_block", bus.err_out, 0);
            if (last_final) begin
                check("end_round", int'(bus.round_out), 0);
                check("end_sel", int'(bus.ark_in_sel), 0);
                check("ark_count", n_ark, nr + 1);
                check("ss_count", n_ss, nr);
                check("mc_count", n_mc, nr - 1);
                check("events_left", q.size(), 0);
                fin = 1'b1;
            end else begin
                idle_inputs();
                bus.key_len_in = kl; bus.dec_in = d;
                if (pend == 0) begin
                    if (punit == 0) bus.ark_ready_in = 1'b1;
                    if (punit == 1) bus.ss_ready_in  = 1'b1;
                    if (punit == 2) bus.mc_ready_in  = 1'b1;
                    if (punit == 0 && q.size() == 0) last_final = 1'b1;
                    if (ab) begin
                        bus.abort_in = 1'b1;
                        aborted      = 1'b1;
                    end
                end
                if (pend >= 0) pend--;
                if ($urandom_range(0, 3) == 0) begin
                    int u2;
                    u2 = (punit + 1 + int'($urandom_range(0, 1))) % 3;
                    if (u2 == 0) bus.ark_ready_in = 1'b1;
                    if (u2 == 1) bus.ss_ready_in  = 1'b1;
                    if (u2 == 2) bus.mc_ready_in  = 1'b1;
                end
                if (inj && punit == 1) begin
                    bus.start_in   = 1'b1;
                    bus.key_len_in = 2'($urandom_range(0, 3));
                    bus.dec_in     = ~d;
                end
                @(posedge clk); #1;
            end
        end
        if (!fin) check("block_timeout", 0, 1);
        idle_inputs();
    endtask

    initial begin
        vec_t tbl[6];
        int   n_ark;
        tbl[0] = '{2'b00, 1'b0, 1'b0, 11};
        tbl[1] = '{2'b01, 1'b1, 1'b0, 13};
        tbl[2] = '{2'b10, 1'b1, 1'b0, 15};
        tbl[3] = '{2'b11, 1'b0, 1'b1, 0};
        tbl[4] = '{2'b00, 1'b1, 1'b0, 11};
        tbl[5] = '{2'b11, 1'b1, 1'b1, 0};

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs_zero", all_outputs(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", all_outputs(), 0);

        // AES-128 enc with every unit replying one cycle after its start.
        run_block(2'b00, 1'b0, 0, 1'b0, -1, -1, n_ark);
        check("aes128_fast_ark", n_ark, 11);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].exp_err) begin
                idle_inputs();
                bus.key_len_in = tbl[i].kl; bus.dec_in = tbl[i].d; bus.start_in = 1'b1;
                @(posedge clk); #1;
                bus.start_in = 1'b0;
                check("err_pulse", bus.err_out, 1);
                check("err_busy", bus.busy_out, 0);
                check("err_no_starts",
                      int'(bus.ss_start_out) + int'(bus.mc_start_out) + int'(bus.ark_start_out), 0);
                @(posedge clk); #1;
                check("err_one_cycle", bus.err_out, 0);
            end else begin
                run_block(tbl[i].kl, tbl[i].d, 3, 1'b0, -1, -1, n_ark);
                check("table_ark_count", n_ark, tbl[i].exp_ark);
            end
        end

        // abort_in alone in IDLE does nothing; start+abort in IDLE: abort wins.
        idle_inputs();
        bus.abort_in = 1'b1;
        @(posedge clk); #1;
        check("idle_abort_noop", all_outputs(), 0);
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        check("start_abort_idle", all_outputs(), 0);

        // abort together with mc_ready in round 5, then a fresh block must still work.
        run_block(2'b00, 1'b0, 2, 1'b0, 5, -1, n_ark);
        run_block(2'b00, 1'b1, 2, 1'b0, -1, -1, n_ark);
        check("after_abort_ark", n_ark, 11);

        // start_in pulses while busy in AES-192 are ignored.
        run_block(2'b01, 1'b0, 2, 1'b1, -1, -1, n_ark);
        check("aes192_inject_ark", n_ark, 13);

        // Async reset in round 7, then a clean AES-128 run.
        run_block(2'b00, 1'b0, 1, 1'b0, -1, 7, n_ark);
        @(posedge clk); #1;
        check("after_reset_idle", all_outputs(), 0);
        run_block(2'b00, 1'b0, 0, 1'b0, -1, -1, n_ark);
        check("after_reset_ark", n_ark, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
